// File: rtl/door_lock_controller.sv
// Keypad door lock: code entry with wrong-code lockout, timed open window,
// remote lock, held-open / forced-door alarms and emergency release.
module door_lock_controller #(
    parameter logic [3:0] PASSWORD     = 4'hA,
    parameter int         OPEN_CYCLES  = 16,
    parameter int         BLOCK_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] code_in,
    input  logic       enter,
    input  logic       door_closed,
    input  logic       remote,
    input  logic       emergency,
    output logic [1:0] state,
    output logic [1:0] error_count,
    output logic       AL,
    output logic       AF,
    output logic       EM,
    output logic       unlock
);

    localparam int MAX_CYCLES = (OPEN_CYCLES > BLOCK_CYCLES) ? OPEN_CYCLES : BLOCK_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0] BLOCK_LOAD = TW'(BLOCK_CYCLES);
    localparam logic [TW-1:0] ONE        = TW'(1);

    typedef enum logic [1:0] {
        ST_AB = 2'b00,
        ST_FE = 2'b01,
        ST_PF = 2'b10
    } state_t;

    // Handshake: none. enter is a one-cycle strobe qualified by the current
    // state and lockout; every other input is a level sampled each rising edge.

    state_t        st_q, st_d;
    logic [1:0]    err_q, err_d;
    logic          al_d, af_d, em_d, unlock_d;
    logic [TW-1:0] open_q, open_d;
    logic [TW-1:0] block_q, block_d;
    logic          blocked;
    logic          open_expiring;

    assign state         = st_q;
    assign blocked       = (err_q == 2'd3);
    // A timer value of 1 means this edge completes the window, so the
    // window lasts exactly the loaded number of cycles.
    assign open_expiring = (open_q <= ONE);

    always_comb begin
        st_d     = st_q;
        err_d    = err_q;
        al_d     = AL;
        af_d     = AF;
        em_d     = EM;
        open_d   = open_q;
        block_d  = block_q;

        if (emergency) begin
            // Timers and error count hold while the emergency is active.
            st_d = ST_AB;
            em_d = 1'b1;
            al_d = 1'b0;
        end else begin
            if ((st_q == ST_FE || st_q == ST_PF) && !door_closed) begin
                af_d = 1'b1;
            end

            if (blocked && st_q != ST_PF) begin
                if (block_q > ONE) begin
                    block_d = block_q - ONE;
                end else begin
                    block_d = '0;
                    err_d   = 2'd0;
                end
            end

            if (EM) begin
                em_d   = 1'b0;
                st_d   = ST_AB;
                open_d = OPEN_LOAD;
            end else begin
                case (st_q)
                    ST_AB: begin
                        open_d = open_expiring ? '0 : open_q - ONE;
                        if (remote && door_closed) begin
                            st_d   = ST_PF;
                            al_d   = 1'b0;
                            open_d = '0;
                        end else if (open_expiring) begin
                            if (door_closed) begin
                                st_d = ST_FE;
                                al_d = 1'b0;
                            end else begin
                                al_d = 1'b1;
                            end
                        end
                    end
                    ST_FE: begin
                        if (remote) begin
                            st_d = ST_PF;
                        end else if (enter && !blocked) begin
                            if (code_in == PASSWORD) begin
                                st_d   = ST_AB;
                                err_d  = 2'd0;
                                af_d   = 1'b0;
                                open_d = OPEN_LOAD;
                            end else begin
                                err_d = err_q + 2'd1;
                                if (err_q == 2'd2) begin
                                    block_d = BLOCK_LOAD;
                                end
                            end
                        end
                    end
                    ST_PF: begin
                        if (!remote) begin
                            st_d = ST_FE;
                        end
                    end
                    default: begin
                        st_d = ST_FE;
                    end
                endcase
            end
        end

        unlock_d = (st_d == ST_AB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_FE;
            err_q       <= 2'd0;
            AL          <= 1'b0;
            AF          <= 1'b0;
            EM          <= 1'b0;
            unlock      <= 1'b0;
            open_q      <= '0;
            block_q     <= '0;
        end else begin
            st_q        <= st_d;
            err_q       <= err_d;
            AL          <= al_d;
            AF          <= af_d;
            EM          <= em_d;
            unlock      <= unlock_d;
            open_q      <= open_d;
            block_q     <= block_d;
        end
    end

    assign error_count = err_q;

endmodule

// File: doc/door_lock_controller.md
DOOR_LOCK_CONTROLLER -- requirements
Module: door_lock_controller

Interface
REQ-001 Parameters SHALL be: PASSWORD, default 4'hA, 4-bit unlock code; OPEN_CYCLES, default 16, open-window length in clk cycles; BLOCK_CYCLES, default 32, lockout length in clk cycles.
REQ-002 Ports SHALL be (name direction width meaning): clk input 1 sole clock, rising edge; rst_n input 1 asynchronous active-low reset.
REQ-003 code_in input 4: code switches, sampled only when enter=1.
REQ-004 enter input 1: single-cycle code-submit pulse, synchronous to clk.
REQ-005 door_closed input 1: door sensor, 1 = closed.
REQ-006 remote input 1: remote-lock level, 1 = lock remotely.
REQ-007 emergency input 1: emergency-release level.
REQ-008 state output 2: 00 = AB (open), 01 = FE (closed), 10 = PF (remotely closed); 11 SHALL never be driven.
REQ-009 error_count output 2: wrong-code count; 3 = BL (blocked).
REQ-010 AL, AF, EM outputs 1 each: door-held-open alarm, forced-door alarm, emergency active.
REQ-011 unlock output 1: lock actuator, 1 = released.
REQ-012 There SHALL be one clock; reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-013 All outputs SHALL be registered; every response SHALL appear on the clk edge following the qualifying input.
REQ-014 unlock SHALL equal 1 exactly when state = AB.
REQ-015 Input priority per cycle SHALL be: emergency > remote > enter.
REQ-016 FE, enter=1, code_in = PASSWORD, error_count < 3: state -> AB; error_count -> 0; AF -> 0; open timer loaded with OPEN_CYCLES.
REQ-017 FE, enter=1, wrong code, error_count < 3: error_count increments; state stays FE.
REQ-018 When error_count reaches 3: load block timer with BLOCK_CYCLES; ignore every enter, correct or not, while it runs.
REQ-019 Block timer expiry: error_count -> 0 on that edge; an enter in the same cycle SHALL be ignored.
REQ-020 AB: open timer decrements every cycle; at 0 with door_closed=1, state -> FE.
REQ-021 AB: open timer at 0 with door_closed=0: AL -> 1; state stays AB until door_closed=1; then state -> FE and AL -> 0 on the same edge.
REQ-022 remote=1 in FE: state -> PF.
REQ-023 remote=1 in AB: state -> PF only once door_closed=1; the AL rules of REQ-021 apply while waiting.
REQ-024 PF: enter SHALL be ignored and error_count frozen; remote=0 -> FE.
REQ-025 door_closed=0 while state is FE or PF: AF -> 1, held until a correct code is accepted (REQ-016) or reset.
REQ-026 emergency=1: state -> AB, EM -> 1, AL -> 0; override PF and BL; open and block timers frozen; error_count held.
REQ-027 emergency 1 -> 0: EM -> 0; state stays AB; open timer reloaded with OPEN_CYCLES; block timer resumes if error_count = 3.
REQ-028 Timer widths SHALL be $clog2(max(OPEN_CYCLES, BLOCK_CYCLES)+1); timers SHALL never wrap below 0.

Reset
REQ-029 rst_n=0 SHALL immediately force: state = FE (01), error_count = 0, AL = AF = EM = 0, unlock = 0, both timers = 0.
REQ-030 Reset asserted mid-operation (AB, PF, BL or emergency) SHALL abandon that operation; after release, operation SHALL restart from FE with no memory of prior errors or alarms.

Verification
REQ-031 Reset, code_in=4'hA, enter pulse -> next edge state=00, unlock=1; door_closed=1 for 16 cycles -> state=01, unlock=0.
REQ-032 Three enters with code_in=4'h3 -> error_count 1, 2, 3; enter with 4'hA during the next 32 cycles -> no change; after 32 cycles error_count=0, then 4'hA -> state=00.
REQ-033 Open with door_closed=0 past 16 cycles -> AL=1, state=00; raise door_closed -> state=01, AL=0 on the same edge.
REQ-034 remote=1 in FE -> state=10; correct enter ignored; door_closed=0 -> AF=1; remote=0 then enter 4'hA -> state=00, AF=0.
REQ-035 error_count=3 and state=10, emergency=1 -> state=00, EM=1, unlock=1, error_count=3; emergency=0 -> EM=0, reopen timer runs 16 cycles.
REQ-036 rst_n pulsed low asynchronously (between clk edges) during AB with AL=1 -> outputs immediately state=01, AL=0, unlock=0, error_count=0.
